// File: rtl/banner_pkg.sv
// Shared types and constants for the scrolling banner controller:
// FSM state encoding, the blank display code and the UART protocol bytes.
package banner_pkg;

  typedef enum logic [1:0] {
    ST_EDIT,
    ST_COPY,
    ST_ACK
  } state_t;

  localparam logic [4:0] BLANK   = 5'd31;
  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h45;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] ESC     = 8'h1B;

  // Buffers are built at the largest supported depth so indices are always 4 bits.
  localparam int MAX_W = 16;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/ascii_to_code5.sv
// Maps an ASCII byte onto the 5-bit glyph code used by the LED mux:
// digits 0..9, letters A..U (either case) 10..30, everything else blank.
module ascii_to_code5
  import banner_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [4:0] code
);

  always_comb begin
    code = BLANK;
    if (ascii >= 8'h30 && ascii <= 8'h39)
      code = 5'(ascii - 8'h30);
    else if (ascii >= 8'h41 && ascii <= 8'h55)
      code = 5'(ascii - 8'd55);
    else if (ascii >= 8'h61 && ascii <= 8'h75)
      code = 5'(ascii - 8'd87);
  end

endmodule

// File: rtl/banner_ctrl.sv
// UART-fed scrolling banner: bytes are edited into a buffer, committed on CR
// into the display buffer, acknowledged over TX, and shown through a 6-wide window.
module banner_ctrl
  import banner_pkg::*;
#(
  parameter int TURNS = 25_000_000,
  parameter int W     = 10,
  parameter int CW    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic [4:0] in0,
  output logic [4:0] in1,
  output logic [4:0] in2,
  output logic [4:0] in3,
  output logic [4:0] in4,
  output logic [4:0] in5
);

  localparam int LW = 5;

  state_t          state;
  logic [LW-1:0]   elen, dlen, off, cnt;
  logic            ovf;
  logic [CW-1:0]   scnt;
  logic [4:0]      ebuf [MAX_W];
  logic [4:0]      dbuf [MAX_W];
  logic [4:0]      disp [6];
  logic [4:0]      disp_next [6];
  logic [LW-1:0]   sum [6];
  logic [LW-1:0]   idx [6];
  logic [4:0]      rx_code;
  logic            accept, tick, edit_write;

  ascii_to_code5 u_map (
    .ascii (rx_data),
    .code  (rx_code)
  );

  assign accept     = rx_valid && rx_ready;
  assign tick       = (scnt == CW'(TURNS - 1));
  assign edit_write = (state == ST_EDIT) && accept && is_printable(rx_data) && (elen < LW'(W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EDIT;
      rx_ready <= 1'b1;
      elen     <= '0;
      dlen     <= '0;
      off      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      scnt     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      scnt <= tick ? '0 : scnt + CW'(1);
      if (tick)
        off <= (dlen > LW'(6) && off != dlen - LW'(1)) ? off + LW'(1) : '0;

      case (state)
        ST_EDIT: begin
          if (accept) begin
            if (rx_data == ESC) begin
              elen <= '0;
              ovf  <= 1'b0;
            end else if (rx_data == CR) begin
              cnt      <= '0;
              rx_ready <= 1'b0;
              if (elen == '0) begin
                state    <= ST_ACK;
                tx_valid <= 1'b1;
                tx_data  <= ovf ? ACK_ERR : ACK_OK;
              end else begin
                state <= ST_COPY;
              end
            end else if (is_printable(rx_data)) begin
              if (elen < LW'(W))
                elen <= elen + LW'(1);
              else
                ovf <= 1'b1;
            end
          end
        end

        // The commit also restarts scrolling so a new message always begins at its head.
        ST_COPY: begin
          cnt <= cnt + LW'(1);
          if (cnt == elen - LW'(1)) begin
            dlen     <= elen;
            off      <= '0;
            scnt     <= '0;
            state    <= ST_ACK;
            tx_valid <= 1'b1;
            tx_data  <= ovf ? ACK_ERR : ACK_OK;
          end
        end

        ST_ACK: begin
          if (tx_ready) begin
            state    <= ST_EDIT;
            rx_ready <= 1'b1;
            tx_valid <= 1'b0;
            elen     <= '0;
            ovf      <= 1'b0;
          end
        end

        default: begin
          state    <= ST_EDIT;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (edit_write)
      ebuf[elen[3:0]] <= rx_code;
    if (state == ST_COPY)
      dbuf[cnt[3:0]] <= ebuf[cnt[3:0]];
  end

  // off < dlen and k <= 5 < dlen, so one conditional subtract replaces the modulo.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      sum[k] = off + LW'(k);
      idx[k] = (sum[k] >= dlen) ? sum[k] - dlen : sum[k];
      if (dlen > LW'(6))
        disp_next[k] = dbuf[idx[k][3:0]];
      else if (LW'(k) < dlen)
        disp_next[k] = dbuf[4'(k)];
      else
        disp_next[k] = BLANK;
    end
  end

  // Frozen while COPY overwrites the display buffer underneath it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 6; k++)
        disp[k] <= BLANK;
    end else if (state != ST_COPY) begin
      for (int k = 0; k < 6; k++)
        disp[k] <= disp_next[k];
    end
  end

  assign in0 = disp[0];
  assign in1 = disp[1];
  assign in2 = disp[2];
  assign in3 = disp[3];
  assign in4 = disp[4];
  assign in5 = disp[5];

endmodule

// File: tb/tb_banner_ctrl.sv
// Randomised and directed bench for banner_ctrl against a queue-based model
// of the edit/display buffers and a time-based scroll position.
module tb_banner_ctrl;

  localparam int TURNS = 4;
  localparam int W     = 10;
  localparam int CW    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       rx_ready, tx_valid;
  logic [7:0] tx_data;
  logic [4:0] in0, in1, in2, in3, in4, in5;
  logic [29:0] disp_vec;

  banner_ctrl #(.TURNS(TURNS), .W(W), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .in4      (in4),
    .in5      (in5)
  );

  assign disp_vec = {in0, in1, in2, in3, in4, in5};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  int mdl_edit[$];
  int mdl_disp[$];
  bit mdl_ovf = 1'b0;
  int e0 = 0;
  logic [7:0] exp_ack = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int code_of(input int b);
    if (b >= 48 && b <= 57) return b - 48;
    if (b >= 65 && b <= 85) return b - 65 + 10;
    if (b >= 97 && b <= 117) return b - 97 + 10;
    return 31;
  endfunction

  // Window visible after posedge number t: scroll step n = floor((t-e0-1)/TURNS).
  function automatic logic [29:0] exp_window(input int t);
    int dl, off, c;
    logic [29:0] v;
    dl = mdl_disp.size();
    off = 0;
    v = '0;
    if (dl > 6) off = ((t - e0 - 1) / TURNS) % dl;
    for (int k = 0; k < 6; k++) begin
      if (dl > 6) c = mdl_disp[(off + k) % dl];
      else if (k < dl) c = mdl_disp[k];
      else c = 31;
      v[29 - 5*k -: 5] = c[4:0];
    end
    return v;
  endfunction

  task automatic check_display(input string tag);
    checkOutput(tag, {2'b00, disp_vec}, {2'b00, exp_window(cyc)});
  endtask

  task automatic send_raw(input logic [7:0] b);
    int guard;
    guard = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!rx_ready) checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    send_raw(b);
    if (b == 8'h1B) begin
      mdl_edit.delete();
      mdl_ovf = 1'b0;
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      if (mdl_edit.size() < W) mdl_edit.push_back(code_of(int'(b)));
      else mdl_ovf = 1'b1;
    end
    check_display("disp_edit");
  endtask

  task automatic send_cr();
    int a, guard;
    logic [29:0] held;
    send_raw(8'h0D);
    a = cyc;
    held = exp_window(a);
    guard = 0;
    forever begin
      checkOutput("copy_rx_ready", 32'(rx_ready), 32'd0);
      checkOutput("copy_hold", {2'b00, disp_vec}, {2'b00, held});
      if (tx_valid || guard >= 40) break;
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ack_latency", 32'(cyc - a), 32'(mdl_edit.size()));
    exp_ack = mdl_ovf ? 8'h45 : 8'h4B;
    checkOutput("ack_byte", 32'(tx_data), 32'(exp_ack));
    if (mdl_edit.size() > 0) begin
      mdl_disp = mdl_edit;
      e0 = cyc;
    end
  endtask

  task automatic finish_ack(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
      checkOutput("ack_valid_hold", 32'(tx_valid), 32'd1);
      checkOutput("ack_data_hold", 32'(tx_data), 32'(exp_ack));
      checkOutput("ack_rx_ready", 32'(rx_ready), 32'd0);
      check_display("disp_ack");
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    checkOutput("ack_done_valid", 32'(tx_valid), 32'd0);
    checkOutput("ack_done_edit", 32'(rx_ready), 32'd1);
    mdl_edit.delete();
    mdl_ovf = 1'b0;
  endtask

  task automatic send_line(input string s, input int hold);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    send_cr();
    finish_ack(hold);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check_display("disp_idle");
    end
  endtask

  task automatic wait_until_step(input int j);
    while ((cyc - e0) < j) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'h00);
    checkOutput("reset_disp", {2'b00, disp_vec}, {2'b00, {6{5'd31}}});
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send_line("HI", 2);
    checkOutput("hi_window", {2'b00, disp_vec}, {2'b00, 5'd17, 5'd18, 5'd31, 5'd31, 5'd31, 5'd31});
    idle(14);

    send_line("12345678", 0);
    wait_until_step(29);
    checkOutput("scroll_tick7", {2'b00, disp_vec}, {2'b00, 5'd8, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5});
    wait_until_step(33);
    checkOutput("scroll_tick8", {2'b00, disp_vec}, {2'b00, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6});
    idle(20);

    send_line("ABCDEFGHIJKL", 1);
    idle(50);

    applyStimulus("A");
    applyStimulus("B");
    applyStimulus(8'h1B);
    applyStimulus("C");
    send_cr();
    checkOutput("esc_ack", 32'(tx_data), 32'h4B);
    finish_ack(0);
    checkOutput("esc_window", {2'b00, disp_vec}, {2'b00, 5'd12, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31});
    idle(6);

    send_line("ok", 20);
    idle(6);

    for (int it = 0; it < 10; it++) begin
      int len, r;
      logic [7:0] b;
      len = $urandom_range(0, 13);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) b = 8'h1B;
        else if (r == 1) b = (($urandom_range(0, 1) == 0) ? 8'h7F : 8'(8'h80 + $urandom_range(0, 127)));
        else if (r == 2) b = 8'(8'h00 + $urandom_range(0, 12));
        else b = 8'($urandom_range(32, 126));
        applyStimulus(b);
      end
      send_cr();
      finish_ack($urandom_range(0, 5));
      idle($urandom_range(5, 40));
    end

    applyStimulus("H");
    applyStimulus("I");
    send_raw(8'h0D);
    rst_n = 1'b0;
    #1;
    checkOutput("midcopy_rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("midcopy_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("midcopy_tx_data", 32'(tx_data), 32'h00);
    checkOutput("midcopy_disp", {2'b00, disp_vec}, {2'b00, {6{5'd31}}});
    mdl_edit.delete();
    mdl_disp.delete();
    mdl_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held_tx_valid", 32'(tx_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_cr();
    checkOutput("post_reset_ack", 32'(tx_data), 32'h4B);
    finish_ack(1);
    idle(10);
    checkOutput("post_reset_blank", {2'b00, disp_vec}, {2'b00, {6{5'd31}}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
